// File: rtl/main_decoder_pkg.sv
// rtl/main_decoder_pkg.sv - opcode, immediate-format and ALU-class encodings shared by the RV32I decoders
package main_decoder_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // All-zero control word: no register write, no memory write, no branch.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/main_decoder_lut.sv
// rtl/main_decoder_lut.sv - pure combinational opcode-to-control table
module main_decoder_lut
  import main_decoder_pkg::*;
(
  input  logic [6:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        ctrl.imm_src   = IMM_S;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_ITYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        ctrl.imm_src = IMM_B;
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALUOP_SUB;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - RV32I main control decoder with sticky illegal flag; MAIN_DECODER_OUT_REG_EN registers the outputs
module main_decoder
  import main_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic       ALUSrc,
  output logic       MemWrite,
  output logic       ResultSrc,
  output logic       Branch,
  output logic [1:0] ALUOp,
  output logic       IllegalOp,
  output logic       IllegalSeen
);

  ctrl_t ctrl_comb;
  ctrl_t ctrl_out;
  logic  illegal_seen;

  main_decoder_lut u_lut (
    .op   (Op),
    .ctrl (ctrl_comb)
  );

`ifdef MAIN_DECODER_OUT_REG_EN
  ctrl_t ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_NOP;
    end else begin
      ctrl_q <= ctrl_comb;
    end
  end

  assign ctrl_out = ctrl_q;
`else
  assign ctrl_out = ctrl_comb;
`endif

  // Sticky: tracks the visible IllegalOp, so it lags one stage more when outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen <= 1'b0;
    end else if (ctrl_out.illegal) begin
      illegal_seen <= 1'b1;
    end
  end

  assign RegWrite    = ctrl_out.reg_write;
  assign ImmSrc      = ctrl_out.imm_src;
  assign ALUSrc      = ctrl_out.alu_src;
  assign MemWrite    = ctrl_out.mem_write;
  assign ResultSrc   = ctrl_out.result_src;
  assign Branch      = ctrl_out.branch;
  assign ALUOp       = ctrl_out.alu_op;
  assign IllegalOp   = ctrl_out.illegal;
  assign IllegalSeen = illegal_seen;

endmodule

// File: tb/tb_main_decoder.sv
// tb/tb_main_decoder.sv - table-driven and randomized checks of main_decoder against a row-table model
module tb_main_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] Op = 7'b0110011;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic       ALUSrc;
  logic       MemWrite;
  logic       ResultSrc;
  logic       Branch;
  logic [1:0] ALUOp;
  logic       IllegalOp;
  logic       IllegalSeen;

  int vectors = 0;
  int miscompares = 0;
  logic model_seen = 1'b0;

  // {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, IllegalOp}
  localparam logic [9:0] ROW_LOAD    = 10'b1_00_1_0_1_0_00_0;
  localparam logic [9:0] ROW_STORE   = 10'b0_01_1_1_0_0_00_0;
  localparam logic [9:0] ROW_RTYPE   = 10'b1_00_0_0_0_0_10_0;
  localparam logic [9:0] ROW_ITYPE   = 10'b1_00_1_0_0_0_10_0;
  localparam logic [9:0] ROW_BRANCH  = 10'b0_10_0_0_0_1_01_0;
  localparam logic [9:0] ROW_ILLEGAL = 10'b0_00_0_0_0_0_00_1;

  typedef struct {
    logic [6:0] op;
    logic [9:0] exp;
    string      name;
  } vec_t;

  logic [9:0] rows [logic [6:0]];
  logic [6:0] legal_ops [5];
  vec_t       table_v [9];
  logic [9:0] dut_word;

  assign dut_word = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, IllegalOp};

  main_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Op          (Op),
    .RegWrite    (RegWrite),
    .ImmSrc      (ImmSrc),
    .ALUSrc      (ALUSrc),
    .MemWrite    (MemWrite),
    .ResultSrc   (ResultSrc),
    .Branch      (Branch),
    .ALUOp       (ALUOp),
    .IllegalOp   (IllegalOp),
    .IllegalSeen (IllegalSeen)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [6:0] op);
    return rows.exists(op) ? rows[op] : ROW_ILLEGAL;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each vector holds Op for one full cycle, so IllegalSeen at check time reflects earlier vectors only.
  task automatic apply(input logic [6:0] op, input logic [9:0] exp, input string name);
    @(negedge clk);
    Op = op;
`ifdef MAIN_DECODER_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    check($sformatf("%s ctrl op=%b", name, op), 32'(dut_word), 32'(exp));
    check($sformatf("%s seen op=%b", name, op), 32'(IllegalSeen), 32'(model_seen));
    if (exp[0]) model_seen = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    Op = 7'b0110011;
    rst_n = 1'b0;
    #1;
    check("reset seen", 32'(IllegalSeen), 32'd0);
`ifdef MAIN_DECODER_OUT_REG_EN
    check("reset ctrl", 32'(dut_word), 32'd0);
`else
    check("reset ctrl follows op", 32'(dut_word), 32'(ROW_RTYPE));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_seen = 1'b0;
  endtask

  initial begin
    logic [6:0] op;

    rows[7'b0000011] = ROW_LOAD;
    rows[7'b0100011] = ROW_STORE;
    rows[7'b0110011] = ROW_RTYPE;
    rows[7'b0010011] = ROW_ITYPE;
    rows[7'b1100011] = ROW_BRANCH;
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};

    table_v[0] = '{7'b0000011, ROW_LOAD,    "load"};
    table_v[1] = '{7'b0100011, ROW_STORE,   "store"};
    table_v[2] = '{7'b0110011, ROW_RTYPE,   "rtype"};
    table_v[3] = '{7'b0010011, ROW_ITYPE,   "itype"};
    table_v[4] = '{7'b1100011, ROW_BRANCH,  "branch"};
    table_v[5] = '{7'b1111111, ROW_ILLEGAL, "all-ones"};
    table_v[6] = '{7'b0110011, ROW_RTYPE,   "rtype after illegal"};
    table_v[7] = '{7'b0000000, ROW_ILLEGAL, "zero"};
    table_v[8] = '{7'b1101111, ROW_ILLEGAL, "jal"};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(table_v[i].op, table_v[i].exp, table_v[i].name);
    end

    // Asynchronous reset between edges clears the sticky flag immediately.
    apply(7'b1111111, ROW_ILLEGAL, "pre-async illegal");
    apply(7'b0110011, ROW_RTYPE, "pre-async legal");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset seen", 32'(IllegalSeen), 32'd0);
`ifdef MAIN_DECODER_OUT_REG_EN
    check("async reset ctrl", 32'(dut_word), 32'd0);
`else
    check("async reset ctrl follows op", 32'(dut_word), 32'(ROW_RTYPE));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_seen = 1'b0;

    // Illegal Op held across reset release.
    @(negedge clk);
    rst_n = 1'b0;
    Op = 7'b1111111;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef MAIN_DECODER_OUT_REG_EN
    check("release illegal first edge", 32'(IllegalSeen), 32'd0);
    @(posedge clk);
    #1;
`endif
    check("release illegal seen", 32'(IllegalSeen), 32'd1);
    do_reset();

`ifdef MAIN_DECODER_OUT_REG_EN
    apply(7'b0000011, ROW_LOAD, "reg load");
    @(negedge clk);
    Op = 7'b0100011;
    #1;
    check("reg memwrite before edge", 32'(MemWrite), 32'd0);
    @(posedge clk);
    #1;
    check("reg memwrite after edge", 32'(MemWrite), 32'd1);
`endif

    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) op = legal_ops[$urandom_range(0, 4)];
      else op = 7'($urandom);
      apply(op, model(op), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/main_decoder.md
# main_decoder

Main control decoder for the single-cycle RV32I core. It sits between instruction fetch and the datapath. It maps the 7-bit opcode to datapath control signals: register write, immediate format, ALU operand select, memory write, result select, branch, and ALU operation class. It also flags unsupported opcodes through a live signal and a sticky status bit.

## Interface
- No parameters.
- clk  input  1  system clock. Clocks the sticky status bit and, when configured, the output register stage.
- rst_n  input  1  reset. Asynchronous, active-low.
- Op  input  7  instruction opcode, instr[6:0].
- RegWrite  output  1  write result to the register file rd.
- ImmSrc  output  2  immediate format: 00 I-type, 01 S-type, 10 B-type; 11 is never driven.
- ALUSrc  output  1  ALU operand B select: 0 = register rs2, 1 = immediate.
- MemWrite  output  1  data memory write enable.
- ResultSrc  output  1  writeback select: 0 = ALU result, 1 = memory read data.
- Branch  output  1  instruction is a conditional branch.
- ALUOp  output  2  ALU operation class: 00 add, 01 subtract/compare, 10 decode from funct3/funct7.
- IllegalOp  output  1  current Op is not supported.
- IllegalSeen  output  1  sticky flag: an unsupported Op has been sampled since reset.

## Operation
Decode is a pure function of Op. Don't-care entries are fixed at 0 so the block is deterministic. Outputs per opcode (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp):
- 0000011, load (lw): 1, 00, 1, 0, 1, 0, 00.
- 0100011, store (sw): 0, 01, 1, 1, 0, 0, 00.
- 0110011, R-type: 1, 00, 0, 0, 0, 0, 10.
- 0010011, I-type ALU: 1, 00, 1, 0, 0, 0, 10.
- 1100011, branch (beq): 0, 10, 0, 0, 0, 1, 01.
- Any other value, including 1111111: all control outputs 0 and IllegalOp = 1.

Unsupported opcodes therefore produce no architectural side effect: no register write, no memory write, no branch.

IllegalSeen:
- Set to 1 on any rising clk edge at which IllegalOp is 1.
- Cleared only by reset.

## Timing
- Default build: all decode outputs and IllegalOp are combinational. Latency is zero, and outputs settle in the same cycle Op changes.
- IllegalSeen is registered. It rises on the first rising edge after an illegal Op is presented.
- Reset value of IllegalSeen is 0.
- Reset asserted mid-operation clears IllegalSeen immediately, without waiting for a clock edge.
- While rst_n is low, the combinational outputs continue to follow Op.
- If an illegal Op is present at the edge where rst_n deasserts, IllegalSeen sets on the next rising edge.

## Configuration
Macro MAIN_DECODER_OUT_REG_EN.
- Defined:
  - All decode outputs and IllegalOp are registered, giving one-cycle latency from Op.
  - Reset value of every registered output is 0, i.e. the "illegal/no-op" control pattern with IllegalOp = 0.
  - IllegalSeen sets one cycle after the registered IllegalOp goes high.
- Undefined: combinational behaviour as described in Timing.

## Structure
- Shared package: opcode localparams (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH), ImmSrc encodings (IMM_I, IMM_S, IMM_B), and ALUOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT). The ALU decoder uses the same package.
- One natural sub-module: main_decoder_lut. It is the pure combinational opcode-to-control table. The top level wraps it with the sticky flag and the optional output register.

## Test plan
- Reset, then sweep Op = 0000011, 0100011, 0110011, 0010011, 1100011 with 10 ns per step → each step matches its row in Operation exactly, and IllegalSeen stays 0.
- Op = 1111111 → all controls 0 and IllegalOp = 1; after the next clk edge IllegalSeen = 1.
- After IllegalSeen = 1, apply legal Op = 0110011 → IllegalOp = 0, IllegalSeen remains 1, RegWrite = 1, ALUOp = 10.
- Pulse rst_n low asynchronously between clk edges while IllegalSeen = 1 → IllegalSeen = 0 immediately.
- Apply Op = 0000000 and 1101111 → treated as illegal: all controls 0, IllegalOp = 1.
- With MAIN_DECODER_OUT_REG_EN defined, step Op from 0000011 to 0100011 → MemWrite goes to 1 only after the next rising clk edge; all registered outputs read 0 during reset.
